// File: rtl/usb_cfg_loader_pkg.sv
// Shared types and constants for the framed USB CDC config stream loader.
package usb_cfg_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK,
        S_RESP
    } state_t;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam logic [7:0] CMD_WRITE       = 8'h01;
    localparam logic [7:0] CMD_PING        = 8'h02;

    localparam logic [7:0] STATUS_OK       = 8'h00;
    localparam logic [7:0] STATUS_BAD_CMD  = 8'h01;
    localparam logic [7:0] STATUS_CHECKSUM = 8'h02;
    localparam logic [7:0] STATUS_TIMEOUT  = 8'h03;

    // A PING carrying payload is treated as malformed.
    function automatic logic [7:0] cmd_status(input logic [7:0] cmd, input logic [15:0] len);
        if (cmd == CMD_WRITE)                   return STATUS_OK;
        else if (cmd == CMD_PING && len == '0)  return STATUS_OK;
        else                                    return STATUS_BAD_CMD;
    endfunction

endpackage

// File: rtl/cfg_word_packer.sv
// Byte-in / word-out packer: places each byte in its slot, strobes one cycle after a word completes.
module cfg_word_packer #(
    parameter int WORD_WIDTH = 32,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  emit,
    output logic                  last,
    output logic                  strobe,
    output logic [WORD_WIDTH-1:0] word
);
    localparam int WB = WORD_WIDTH / 8;
    localparam int IW = (WB > 1) ? $clog2(WB) : 1;

    logic [IW-1:0]         idx;
    logic [IW-1:0]         slot;
    logic [WORD_WIDTH-1:0] acc;
    logic [WORD_WIDTH-1:0] merged;

    assign last = (idx == IW'(WB - 1));
    assign slot = (MSB_FIRST != 0) ? IW'(WB - 1) - idx : idx;

    always_comb begin
        merged = acc;
        merged[slot*8 +: 8] = byte_data;
    end

    // The output word only moves when a word is actually emitted, so it holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= '0;
            acc    <= '0;
            word   <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clear) begin
                idx <= '0;
            end else if (byte_valid) begin
                acc <= merged;
                idx <= last ? '0 : idx + 1'b1;
                if (last && emit) begin
                    word   <= merged;
                    strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/usb_cfg_stream_loader.sv
// Framed config loader: SYNC/CMD/LEN frames from one CDC channel -> config words + status byte.
// Optional trailing checksum byte enabled by `CFG_LOADER_CHECKSUM_EN.
module usb_cfg_stream_loader
    import usb_cfg_loader_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int CFG_CHANNEL    = 0,
    parameter int WORD_WIDTH     = 32,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [CHANNELS*8-1:0] out_data_i,
    input  logic [CHANNELS-1:0]   out_valid_i,
    output logic [CHANNELS-1:0]   out_ready_o,
    output logic [CHANNELS*8-1:0] in_data_o,
    output logic [CHANNELS-1:0]   in_valid_o,
    input  logic [CHANNELS-1:0]   in_ready_i,
    output logic                  word_write_strobe_o,
    output logic [WORD_WIDTH-1:0] write_data_o,
    output logic                  busy_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CFG_LOADER_CHECKSUM_EN
    localparam state_t DONE_STATE = S_CHECK;
`else
    localparam state_t DONE_STATE = S_RESP;
`endif

    state_t        state, state_nx;
    logic [7:0]    rx;
    logic          accept, active, timeout, last_byte;
    logic [7:0]    cmd, status;
    logic [15:0]   len, word_cnt;
    logic [TW-1:0] idle_cnt;
    logic          write_en;
    logic          unused_ok;

    assign rx        = out_data_i[CFG_CHANNEL*8 +: 8];
    assign accept    = out_valid_i[CFG_CHANNEL] && (state != S_RESP);
    assign active    = (state != S_IDLE) && (state != S_RESP);
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign timeout   = active && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy_o    = (state != S_IDLE);
    assign unused_ok = ^{out_data_i, in_ready_i};

    always_comb begin
        out_ready_o              = '1;
        out_ready_o[CFG_CHANNEL] = (state != S_RESP);
        in_valid_o               = '0;
        in_valid_o[CFG_CHANNEL]  = (state == S_RESP);
        in_data_o                = '0;
        in_data_o[CFG_CHANNEL*8 +: 8] = (state == S_RESP) ? status : 8'h00;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (timeout) begin
            state_nx = S_RESP;
        end else begin
            case (state)
                S_IDLE:    if (accept && rx == SYNC_BYTE) state_nx = S_CMD;
                S_CMD:     if (accept) state_nx = S_LEN_LO;
                S_LEN_LO:  if (accept) state_nx = S_LEN_HI;
                S_LEN_HI:  if (accept) state_nx = ({rx, len[7:0]} == 16'd0) ? DONE_STATE : S_PAYLOAD;
                S_PAYLOAD: if (accept && last_byte && word_cnt == len - 16'd1) state_nx = DONE_STATE;
`ifdef CFG_LOADER_CHECKSUM_EN
                S_CHECK:   if (accept) state_nx = S_RESP;
`endif
                S_RESP:    if (in_ready_i[CFG_CHANNEL]) state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            sum <= '0;
        else if (accept && state == S_IDLE)
            sum <= '0;
        else if (accept && state != S_CHECK)
            sum <= sum + rx;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idle_cnt <= '0;
            cmd      <= '0;
            len      <= '0;
            word_cnt <= '0;
            status   <= STATUS_OK;
            write_en <= 1'b0;
        end else begin
            if (accept || !active) idle_cnt <= '0;
            else                   idle_cnt <= idle_cnt + 1'b1;

            if (timeout) begin
                status <= STATUS_TIMEOUT;
            end else if (accept) begin
                case (state)
                    S_CMD: begin
                        cmd      <= rx;
                        write_en <= (rx == CMD_WRITE);
                    end
                    S_LEN_LO: len[7:0] <= rx;
                    S_LEN_HI: begin
                        len[15:8] <= rx;
                        word_cnt  <= '0;
                        status    <= cmd_status(cmd, {rx, len[7:0]});
                    end
                    S_PAYLOAD: if (last_byte) word_cnt <= word_cnt + 16'd1;
`ifdef CFG_LOADER_CHECKSUM_EN
                    S_CHECK: if (sum + rx != 8'h00) status <= STATUS_CHECKSUM;
`endif
                    default: ;
                endcase
            end
        end
    end

    cfg_word_packer #(
        .WORD_WIDTH (WORD_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_packer (
        .clk        (clk_i),
        .reset      (reset_i),
        .clear      (timeout || (accept && state == S_IDLE)),
        .byte_valid (accept && state == S_PAYLOAD),
        .byte_data  (rx),
        .emit       (write_en),
        .last       (last_byte),
        .strobe     (word_write_strobe_o),
        .word       (write_data_o)
    );

endmodule
